// File: rtl/reg_seq_pkg.sv
// rtl/reg_seq_pkg.sv - opcodes, FSM state encoding and entry field widths for reg_seq_player
package reg_seq_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_WRITE = 2'b00;
  localparam logic [OP_W-1:0] OP_POLL  = 2'b01;
  localparam logic [OP_W-1:0] OP_WAIT  = 2'b10;
  localparam logic [OP_W-1:0] OP_END   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_GAP,
    S_DELAY,
    S_DONE
  } state_t;

endpackage

// File: rtl/reg_seq_table.sv
// rtl/reg_seq_table.sv - command register array: synchronous write, two async read ports, reset to END
module reg_seq_table
  import reg_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OP_W-1:0]   wr_op,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_mask,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [OP_W-1:0]   rd_op,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rd_mask,
  input  logic [IDX_W-1:0]  pk_idx,
  output logic [OP_W-1:0]   pk_op
);

  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] mask_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= OP_END;
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else if (wr_en) begin
      op_q[wr_idx]   <= wr_op;
      addr_q[wr_idx] <= wr_addr;
      data_q[wr_idx] <= wr_data;
      mask_q[wr_idx] <= wr_mask;
    end
  end

  // Second port peeks at the following entry so the FSM can decide END before issuing it
  assign rd_op   = op_q[rd_idx];
  assign rd_addr = addr_q[rd_idx];
  assign rd_data = data_q[rd_idx];
  assign rd_mask = mask_q[rd_idx];
  assign pk_op   = op_q[pk_idx];

endmodule

// File: rtl/reg_seq_player.sv
// rtl/reg_seq_player.sv - replays a command table as register writes, polls and delays
// Optional REG_SEQ_TIMEOUT_EN adds a per-entry timeout that flags error/err_idx.
module reg_seq_player
  import reg_seq_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int SEQ_DEPTH      = 16,
  parameter int POLL_GAP       = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          jtag_m_axi_aclk,
  input  logic                          jtag_m_axi_areset,
  input  logic                          cmd_wr_en,
  input  logic [$clog2(SEQ_DEPTH)-1:0]  cmd_wr_idx,
  input  logic [1:0]                    cmd_op,
  input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     cmd_data,
  input  logic [AXI_DATA_WIDTH-1:0]     cmd_mask,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(SEQ_DEPTH)-1:0]  err_idx,
  output logic [AXI_DATA_WIDTH-1:0]     last_rdata,
  output logic                          wr_req,
  output logic                          rd_req,
  output logic [AXI_ADDR_WIDTH-1:0]     addr,
  output logic [AXI_DATA_WIDTH-1:0]     wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   wstrb,
  input  logic                          op_ack,
  input  logic [AXI_DATA_WIDTH-1:0]     rdata
);

  localparam int IDX_W = $clog2(SEQ_DEPTH);

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          pk_idx;
  logic [AXI_DATA_WIDTH-1:0] cnt;
  logic [OP_W-1:0]           cur_op;
  logic [OP_W-1:0]           nxt_op;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [AXI_DATA_WIDTH-1:0] cur_data;
  logic [AXI_DATA_WIDTH-1:0] cur_mask;
  logic                      poll_hit;
  logic                      last_entry;
  logic                      adv;

  // In IDLE the peek port looks at entry 0 so start can skip straight to DONE
  assign pk_idx     = (state == S_IDLE) ? '0 : idx + 1'b1;
  assign last_entry = (idx == IDX_W'(SEQ_DEPTH - 1)) || (nxt_op == OP_END);
  assign poll_hit   = ((rdata ^ cur_data) & cur_mask) == '0;

  reg_seq_table #(
    .ADDR_W (AXI_ADDR_WIDTH),
    .DATA_W (AXI_DATA_WIDTH),
    .DEPTH  (SEQ_DEPTH),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk     (jtag_m_axi_aclk),
    .rst     (jtag_m_axi_areset),
    .wr_en   (cmd_wr_en && (state == S_IDLE)),
    .wr_idx  (cmd_wr_idx),
    .wr_op   (cmd_op),
    .wr_addr (cmd_addr),
    .wr_data (cmd_data),
    .wr_mask (cmd_mask),
    .rd_idx  (idx),
    .rd_op   (cur_op),
    .rd_addr (cur_addr),
    .rd_data (cur_data),
    .rd_mask (cur_mask),
    .pk_idx  (pk_idx),
    .pk_op   (nxt_op)
  );

  always_comb begin
    adv = 1'b0;
    case (state)
      S_ISSUE:    adv = (cur_op == OP_WAIT) && (cur_data == '0);
      S_WAIT_ACK: adv = op_ack && ((cur_op != OP_POLL) || poll_hit);
      S_DELAY:    adv = (cnt == AXI_DATA_WIDTH'(1));
      default:    adv = 1'b0;
    endcase
  end

`ifdef REG_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_live;
  assign to_live = ((state == S_ISSUE) || (state == S_WAIT_ACK) || (state == S_GAP))
                   && (cur_op != OP_WAIT);
`endif

  always_ff @(posedge jtag_m_axi_aclk) begin
    if (jtag_m_axi_areset) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_idx    <= '0;
      last_rdata <= '0;
      wr_req     <= 1'b0;
      rd_req     <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      wstrb      <= '0;
`ifdef REG_SEQ_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      wr_req <= 1'b0;
      rd_req <= 1'b0;
      done   <= 1'b0;
      if (adv) begin
        idx   <= idx + 1'b1;
        state <= last_entry ? S_DONE : S_ISSUE;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            idx   <= '0;
            error <= 1'b0;
            state <= (nxt_op == OP_END) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          case (cur_op)
            OP_WRITE: begin
              wr_req <= 1'b1;
              addr   <= cur_addr;
              wdata  <= cur_data;
              wstrb  <= '1;
              state  <= S_WAIT_ACK;
            end
            OP_POLL: begin
              rd_req <= 1'b1;
              addr   <= cur_addr;
              state  <= S_WAIT_ACK;
            end
            OP_WAIT: begin
              if (!adv) begin
                cnt   <= cur_data;
                state <= S_DELAY;
              end
            end
            default: state <= S_DONE;
          endcase
        end
        S_WAIT_ACK: begin
          if (op_ack) begin
            if (cur_op == OP_POLL) last_rdata <= rdata;
            if (!adv) begin
              cnt   <= AXI_DATA_WIDTH'(POLL_GAP);
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (cnt == AXI_DATA_WIDTH'(1)) state <= S_ISSUE;
          else cnt <= cnt - 1'b1;
        end
        S_DELAY: begin
          if (!adv) cnt <= cnt - 1'b1;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`ifdef REG_SEQ_TIMEOUT_EN
      // Counter spans the first issue, ack wait and every poll retry of one entry
      if ((state == S_IDLE) || adv) begin
        to_cnt <= '0;
      end else if (to_live) begin
        if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          error   <= 1'b1;
          err_idx <= idx;
          wr_req  <= 1'b0;
          rd_req  <= 1'b0;
          state   <= S_DONE;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule
